// File: rtl/sample_age_fifo_pkg.sv
// Shared definitions for the sample-age FIFO: default sizing used by the
// window FIFO and its storage, plus the window-length clamp helper.
package sample_age_fifo_pkg;

   // Default sample width in bits.
   localparam int DEF_DATA_LENGTH = 16;
   // Default maximum window length, which is also the buffer depth.
   localparam int DEF_WMAX        = 8;
   // Default pointer width, ceil(log2(DEF_WMAX)); must be at least 1.
   localparam int DEF_LOG_WMAX    = 3;

   // Map a requested window length onto the legal range 1..wmax.
   // A zero request behaves as a one-deep window.
   // An oversize request saturates at the buffer depth.
   function automatic int clamp_window(input int w, input int wmax);
      if (w <= 0) begin
         return 1;
      end else if (w > wmax) begin
         return wmax;
      end else begin
         return w;
      end
   endfunction

endpackage : sample_age_fifo_pkg

// File: rtl/sample_age_fifo_ram.sv
// sample_ram: WMAX x DATA_LENGTH sample storage with one write port and one
// registered read port. A read and a write to the same slot in the same cycle
// return the data held before the write (read-before-write).
module sample_ram
   import sample_age_fifo_pkg::*;
#(
   parameter int DATA_LENGTH = DEF_DATA_LENGTH,
   parameter int WMAX        = DEF_WMAX,
   parameter int LOG_WMAX    = DEF_LOG_WMAX
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   we,
   input  logic [LOG_WMAX-1:0]    waddr,
   input  logic [DATA_LENGTH-1:0] wdata,
   input  logic                   re,
   input  logic [LOG_WMAX-1:0]    raddr,
   output logic [DATA_LENGTH-1:0] rdata
);

   logic [DATA_LENGTH-1:0] mem [WMAX];
   logic [DATA_LENGTH-1:0] rdata_q;
   logic [DATA_LENGTH-1:0] rdata_d;

   // Select the next read register value: load on a read, otherwise hold.
   always_comb begin
      // NOTE: combinational blocks use blocking '=' and give every output a
      // default first, so the result is pure logic with no inferred latch.
      rdata_d = rdata_q;
      if (re) begin
         rdata_d = mem[raddr];
      end
   end

   // Write the incoming sample into its slot.
   always_ff @(posedge clk) begin
      // NOTE: the storage array is deliberately not reset; clearing it would
      // turn a compact RAM into a flop array, and the window logic never
      // reads a slot before writing it after reset or flush.
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Registered read data; cleared by reset, otherwise held between reads.
   always_ff @(posedge clk) begin
      // NOTE: sequential blocks use non-blocking '<=' so every flop samples
      // pre-edge values and simulation ordering cannot change the result.
      if (reset) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule : sample_ram

// File: rtl/sample_age_fifo.sv
// sample_age_fifo: sliding-window history buffer for a running-order filter.
// Every accepted sample is stored; once the window holds w_act samples, each
// further push also evicts the sample written w_act pushes earlier onto
// old_out, one cycle later, with a one-cycle old_valid pulse.
module sample_age_fifo
   import sample_age_fifo_pkg::*;
#(
   parameter int DATA_LENGTH = DEF_DATA_LENGTH,
   parameter int WMAX        = DEF_WMAX,
   parameter int LOG_WMAX    = DEF_LOG_WMAX
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [DATA_LENGTH-1:0] x_in,
   input  logic                   x_valid,
   output logic                   x_ready,
   input  logic [LOG_WMAX:0]      w,
   input  logic                   flush,
   output logic [DATA_LENGTH-1:0] old_out,
   output logic                   old_valid,
   output logic                   window_full,
   output logic [LOG_WMAX:0]      fill_count
);

   // Buffer depth and last slot index in the widths they are compared at.
   localparam logic [LOG_WMAX:0]   WMAX_C   = (LOG_WMAX+1)'(WMAX);
   localparam logic [LOG_WMAX-1:0] PTR_LAST = LOG_WMAX'(WMAX - 1);

   logic [LOG_WMAX-1:0] wr_ptr_q;
   logic [LOG_WMAX-1:0] wr_ptr_d;
   logic [LOG_WMAX:0]   fill_count_q;
   logic [LOG_WMAX:0]   fill_count_d;
   logic [LOG_WMAX:0]   w_act_q;
   logic [LOG_WMAX:0]   w_act_d;
   logic                old_valid_q;
   logic                old_valid_d;

   logic [LOG_WMAX:0]   w_clamped;
   logic [LOG_WMAX-1:0] rd_addr;
   logic                push;
   logic                evict;

   // Flush owns the cycle: no sample is accepted while history is discarded.
   assign x_ready = ~flush;
   assign push    = x_valid & x_ready;
   // A push into an already full window displaces its oldest sample.
   assign evict   = push & (fill_count_q == w_act_q);

   // Requested window length forced into 1..WMAX.
   always_comb begin
      w_clamped = (LOG_WMAX+1)'(clamp_window(int'(w), WMAX));
   end

   // Oldest slot: (wr_ptr - w_act) mod WMAX, taken from the pre-write pointer.
   always_comb begin
      logic [LOG_WMAX:0] wr_ext;
      wr_ext = {1'b0, wr_ptr_q};
      if (wr_ext >= w_act_q) begin
         rd_addr = LOG_WMAX'(wr_ext - w_act_q);
      end else begin
         rd_addr = LOG_WMAX'(wr_ext + WMAX_C - w_act_q);
      end
   end

   // Next-state logic for pointer, fill count, window length and valid pulse.
   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      fill_count_d = fill_count_q;
      w_act_d      = w_act_q;
      old_valid_d  = 1'b0;
      if (flush) begin
         wr_ptr_d     = '0;
         fill_count_d = '0;
         w_act_d      = w_clamped;
      end else begin
         old_valid_d = evict;
         if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            if (!evict) begin
               fill_count_d = fill_count_q + 1'b1;
            end
         end
      end
   end

   // Control state; reset overrides flush and push and reloads the window.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q     <= '0;
         fill_count_q <= '0;
         w_act_q      <= w_clamped;
         old_valid_q  <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         fill_count_q <= fill_count_d;
         w_act_q      <= w_act_d;
         old_valid_q  <= old_valid_d;
      end
   end

   // Sample storage; its read register is old_out, loaded only on eviction,
   // so old_out holds across idle cycles and flushes.
   sample_ram #(
      .DATA_LENGTH (DATA_LENGTH),
      .WMAX        (WMAX),
      .LOG_WMAX    (LOG_WMAX)
   ) u_sample_ram (
      .clk   (clk),
      .reset (reset),
      .we    (push),
      .waddr (wr_ptr_q),
      .wdata (x_in),
      .re    (evict),
      .raddr (rd_addr),
      .rdata (old_out)
   );

   assign old_valid   = old_valid_q;
   assign fill_count  = fill_count_q;
   assign window_full = (fill_count_q == w_act_q);

endmodule : sample_age_fifo

// File: tb/tb_sample_age_fifo.sv
// Self-checking bench for sample_age_fifo: directed pushes with hand-computed
// evictions queued into a scoreboard; a monitor pops one entry per old_valid.
module tb_sample_age_fifo;

   localparam int DL = 16;
   localparam int WM = 8;
   localparam int LW = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic [DL-1:0] x_in;
   logic          x_valid;
   logic          x_ready;
   logic [LW:0]   w;
   logic          flush;
   logic [DL-1:0] old_out;
   logic          old_valid;
   logic          window_full;
   logic [LW:0]   fill_count;

   int vectors    = 0;
   int miscompares = 0;
   int exp_q [$];

   sample_age_fifo #(
      .DATA_LENGTH (DL),
      .WMAX        (WM),
      .LOG_WMAX    (LW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .x_in        (x_in),
      .x_valid     (x_valid),
      .x_ready     (x_ready),
      .w           (w),
      .flush       (flush),
      .old_out     (old_out),
      .old_valid   (old_valid),
      .window_full (window_full),
      .fill_count  (fill_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int actual, input int expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Monitor: every eviction pulse must match the next queued expectation.
   always @(negedge clk) begin
      if (old_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_eviction: got old_out=%0d, expected no eviction (t=%0t)",
                     old_out, $time);
         end else begin
            check("old_out", int'(old_out), exp_q.pop_front());
         end
      end
   end

   task automatic push(input int v);
      x_in    = DL'(v);
      x_valid = 1'b1;
      @(posedge clk);
      #1;
      x_valid = 1'b0;
   endtask

   task automatic push_ev(input int v, input int ev);
      exp_q.push_back(ev);
      push(v);
   endtask

   task automatic do_flush(input int new_w, input bit with_sample);
      w       = (LW+1)'(new_w);
      flush   = 1'b1;
      x_valid = with_sample;
      x_in    = 16'hdead;
      #1;
      check("x_ready_during_flush", int'(x_ready), 0);
      @(posedge clk);
      #1;
      flush   = 1'b0;
      x_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      repeat (3) @(posedge clk);
      #1;
      check({tag, "_scoreboard_empty"}, exp_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset   = 1'b1;
      w       = 4'd4;
      flush   = 1'b0;
      x_valid = 1'b0;
      x_in    = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_old_out", int'(old_out), 0);
      check("reset_old_valid", int'(old_valid), 0);
      check("reset_fill_count", int'(fill_count), 0);
      check("reset_window_full", int'(window_full), 0);
      check("reset_x_ready", int'(x_ready), 1);
      reset = 1'b0;

      // Window 4: evictions 10 and 20 on the 5th and 6th pushes.
      push(10);
      push(20);
      push(30);
      check("w4_not_full_after_3", int'(window_full), 0);
      push(40);
      check("w4_full_after_4", int'(window_full), 1);
      check("w4_fill_after_4", int'(fill_count), 4);
      push_ev(50, 10);
      push_ev(60, 20);
      drain("w4");
      check("w4_fill_steady", int'(fill_count), 4);
      check("w4_old_out_held", int'(old_out), 20);

      // w changes outside reset/flush are ignored: still a 4-deep window.
      w = 4'd2;
      push_ev(70, 30);
      drain("w_ignored");
      check("w_ignored_fill", int'(fill_count), 4);

      // Flush to window 1; old_out holds its last value.
      do_flush(1, 1'b0);
      check("flush_fill", int'(fill_count), 0);
      check("flush_old_valid", int'(old_valid), 0);
      check("flush_old_out_held", int'(old_out), 30);
      push(7);
      check("w1_full_after_1", int'(window_full), 1);
      push_ev(8, 7);
      push_ev(9, 8);
      drain("w1");
      check("w1_fill", int'(fill_count), 1);

      // w = WMAX+5 saturates to WMAX; 2*WMAX ramp wraps the pointer twice.
      do_flush(WM + 5, 1'b0);
      for (int i = 0; i < WM; i++) push(i);
      check("wmax_full", int'(window_full), 1);
      for (int i = 0; i < WM; i++) push_ev(WM + i, i);
      drain("wmax");
      check("wmax_fill", int'(fill_count), WM);

      // w = 0 behaves as a one-deep window.
      do_flush(0, 1'b0);
      push(100);
      push_ev(101, 100);
      push_ev(102, 101);
      drain("w0");
      check("w0_fill", int'(fill_count), 1);

      // Flush with a simultaneous sample: sample dropped, new window 2.
      do_flush(3, 1'b0);
      push(1);
      push(2);
      push(3);
      check("w3_full", int'(window_full), 1);
      do_flush(2, 1'b1);
      check("flush_drop_fill", int'(fill_count), 0);
      push(4);
      push(5);
      push_ev(6, 4);
      drain("flush_drop");
      check("w2_full", int'(window_full), 1);

      // Reset mid-stream with a full window, then refill with no stale data.
      w     = 4'd3;
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("midreset_fill", int'(fill_count), 0);
      check("midreset_old_valid", int'(old_valid), 0);
      check("midreset_old_out", int'(old_out), 0);
      check("midreset_window_full", int'(window_full), 0);
      reset = 1'b0;
      push(11);
      push(12);
      push(13);
      check("refill_full", int'(window_full), 1);
      push_ev(14, 11);
      drain("refill");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_sample_age_fifo
